rc5_key_sched_ctrl: RTL and testbench

RC5_KEY_SCHED_CTRL -- requirements
Module: rc5_key_sched_ctrl

---
 rtl/rc5_pkg.sv | 32 +++
 rtl/rc5_key_sched_ctrl_if.sv | 32 +++
 rtl/rc5_rotl.sv | 15 +
 rtl/rc5_key_sched_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rc5_key_sched_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc5_pkg.sv
// Shared constants, derived address widths and controller state type for the
// RC5-32/12/16 key-schedule controller.
package rc5_pkg;

    localparam int W    = 32;
    localparam int U    = W / 8;
    localparam int B    = 16;
    localparam int R    = 12;
    localparam int T    = 2 * (R + 1);
    localparam int C    = B / U;
    localparam int NMIX = 3 * ((T > C) ? T : C);

    localparam int KAW  = $clog2(B);
    localparam int LAW  = $clog2(C);
    localparam int SAW  = $clog2(T);
    localparam int MW   = $clog2(NMIX);

    localparam logic [W-1:0] PW = 32'hB7E1_5163;
    localparam logic [W-1:0] QW = 32'h9E37_79B9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RD,
        LOAD_ACC,
        INIT_S,
        MIX_RD,
        MIX_A,
        MIX_B,
        FIN
    } state_t;

endpackage

// File: rtl/rc5_key_sched_ctrl_if.sv
// Control handshake plus key, L and S RAM ports of the key-schedule controller.
interface rc5_key_sched_ctrl_if;
    import rc5_pkg::*;

    logic           start;
    logic           busy;
    logic           done;

    logic [KAW-1:0] key_addr;
    logic [7:0]     key_rdata;

    logic [LAW-1:0] l_addr;
    logic           l_we;
    logic [W-1:0]   l_wdata;
    logic [W-1:0]   l_rdata;

    logic [SAW-1:0] s_addr;
    logic           s_we;
    logic [W-1:0]   s_wdata;
    logic [W-1:0]   s_rdata;

    modport master (
        input  start, key_rdata, l_rdata, s_rdata,
        output busy, done, key_addr, l_addr, l_we, l_wdata, s_addr, s_we, s_wdata
    );

    modport slave (
        output start, key_rdata, l_rdata, s_rdata,
        input  busy, done, key_addr, l_addr, l_we, l_wdata, s_addr, s_we, s_wdata
    );

endinterface

// File: rtl/rc5_rotl.sv
// Combinational W-bit rotate-left by a 5-bit amount.
module rc5_rotl #(
    parameter int W = rc5_pkg::W
) (
    input  logic [W-1:0] din,
    input  logic [4:0]   amt,
    output logic [W-1:0] dout
);

    // A right shift by the full width yields zero, so amt == 0 passes din through.
    always_comb begin
        dout = (din << amt) | (din >> (W - int'(amt)));
    end

endmodule

// File: rtl/rc5_key_sched_ctrl.sv
// RC5 key-expansion controller: loads the key into L, fills S with the magic
// constants, then runs the 3*max(T,C) mixing passes against external sync-read RAMs.
module rc5_key_sched_ctrl #(
    parameter int W = rc5_pkg::W,
    parameter int B = rc5_pkg::B,
    parameter int R = rc5_pkg::R
) (
    input  logic                 clk,
    input  logic                 rst,
    rc5_key_sched_ctrl_if.master bus
);
    import rc5_pkg::*;

    localparam int T    = 2 * (R + 1);
    localparam int C    = B / 4;
    localparam int NMIX = 3 * ((T > C) ? T : C);
    localparam int KW   = $clog2(B);
    localparam int LW   = $clog2(C);
    localparam int SW   = $clog2(T);
    localparam int CW   = $clog2(NMIX);

    state_t        state;
    logic          busy_q;
    logic          done_q;
    logic [KW-1:0] k;
    logic [LW-1:0] j;
    logic [SW-1:0] i;
    logic [CW-1:0] m;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  acc;
    logic [W-1:0]  s_run;
    logic [W-1:0]  l_cap;

    logic [W-1:0]  acc_new;
    logic [W-1:0]  a_sum;
    logic [W-1:0]  ab_sum;
    logic [W-1:0]  b_sum;
    logic [W-1:0]  a_new;
    logic [W-1:0]  b_new;

    always_comb begin
        acc_new = (acc << 8) + {{(W-8){1'b0}}, bus.key_rdata};
        a_sum   = bus.s_rdata + a_reg + b_reg;
        ab_sum  = a_reg + b_reg;
        b_sum   = l_cap + ab_sum;
    end

    rc5_rotl #(.W(W)) u_rotl_a (
        .din  (a_sum),
        .amt  (5'd3),
        .dout (a_new)
    );

    rc5_rotl #(.W(W)) u_rotl_b (
        .din  (b_sum),
        .amt  (ab_sum[4:0]),
        .dout (b_new)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // RAM ports are decoded from the registered state so write data can use
    // the read data returned in the same cycle.
    always_comb begin
        bus.key_addr = '0;
        bus.l_addr   = '0;
        bus.l_we     = 1'b0;
        bus.l_wdata  = '0;
        bus.s_addr   = '0;
        bus.s_we     = 1'b0;
        bus.s_wdata  = '0;
        case (state)
            LOAD_RD: bus.key_addr = k;
            LOAD_ACC: begin
                bus.l_addr = k[KW-1:2];
                if (k[1:0] == 2'b00) begin
                    bus.l_we    = 1'b1;
                    bus.l_wdata = acc_new;
                end
            end
            INIT_S: begin
                bus.s_addr  = i;
                bus.s_we    = 1'b1;
                bus.s_wdata = s_run;
            end
            MIX_RD: begin
                bus.s_addr = i;
                bus.l_addr = j;
            end
            MIX_A: begin
                bus.s_addr  = i;
                bus.s_we    = 1'b1;
                bus.s_wdata = a_new;
            end
            MIX_B: begin
                bus.l_addr  = j;
                bus.l_we    = 1'b1;
                bus.l_wdata = b_new;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            k      <= '0;
            j      <= '0;
            i      <= '0;
            m      <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            s_run  <= '0;
            l_cap  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= LOAD_RD;
                        busy_q <= 1'b1;
                        k      <= KW'(B - 1);
                        acc    <= '0;
                    end
                end
                LOAD_RD: state <= LOAD_ACC;
                LOAD_ACC: begin
                    acc <= (k[1:0] == 2'b00) ? '0 : acc_new;
                    if (k == '0) begin
                        state <= INIT_S;
                        i     <= '0;
                        s_run <= PW;
                    end else begin
                        k     <= k - 1'b1;
                        state <= LOAD_RD;
                    end
                end
                INIT_S: begin
                    s_run <= s_run + QW;
                    if (i == SW'(T - 1)) begin
                        state <= MIX_RD;
                        i     <= '0;
                        j     <= '0;
                        m     <= '0;
                        a_reg <= '0;
                        b_reg <= '0;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                MIX_RD: state <= MIX_A;
                MIX_A: begin
                    a_reg <= a_new;
                    l_cap <= bus.l_rdata;
                    state <= MIX_B;
                end
                MIX_B: begin
                    b_reg <= b_new;
                    i     <= (i == SW'(T - 1)) ? '0 : i + 1'b1;
                    j     <= (j == LW'(C - 1)) ? '0 : j + 1'b1;
                    m     <= m + 1'b1;
                    if (m == CW'(NMIX - 1)) begin
                        state  <= FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= MIX_RD;
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
// Self-checking bench: sync-read RAM models plus a software RC5 key schedule
// that predicts every write, busy/done and the final RAM contents.
module tb_rc5_key_sched_ctrl;

    localparam logic [31:0] PW_C = 32'hB7E15163;
    localparam logic [31:0] QW_C = 32'h9E3779B9;
    localparam int          NBUSY = 292;

    logic clk;
    logic rst;

    rc5_key_sched_ctrl_if bus ();

    rc5_key_sched_ctrl #(.W(32), .B(16), .R(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  key_mem [16];
    logic [31:0] l_mem   [4];
    logic [31:0] s_mem   [32];

    bit          e_swe [NBUSY];
    logic [4:0]  e_sa  [NBUSY];
    logic [31:0] e_sd  [NBUSY];
    bit          e_lwe [NBUSY];
    logic [1:0]  e_la  [NBUSY];
    logic [31:0] e_ld  [NBUSY];
    logic [31:0] fin_s [26];
    logic [31:0] fin_l [4];

    int          off = -1;
    bit          eb;
    int          ld_n;
    logic [31:0] ld_cap [4];
    logic [1:0]  ld_adr [4];
    logic [31:0] cap_s0, cap_s1, cap_s25, cap_mix_d;
    logic [4:0]  cap_mix_a;
    logic [31:0] lit_l [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int s);
        int r;
        r = s % 32;
        return (r == 0) ? x : ((x << r) | (x >> (32 - r)));
    endfunction

    // Software key schedule, annotated with the busy-cycle offset of each write.
    task automatic build_model();
        logic [31:0] lv [4];
        logic [31:0] sv [26];
        logic [31:0] a, b;
        int ii, jj, o;
        for (int c = 0; c < NBUSY; c++) begin
            e_swe[c] = 0; e_lwe[c] = 0;
            e_sa[c] = '0; e_la[c] = '0; e_sd[c] = '0; e_ld[c] = '0;
        end
        for (int q = 0; q < 4; q++) lv[q] = '0;
        for (int kk = 15; kk >= 0; kk--) begin
            lv[kk/4] = (lv[kk/4] << 8) + {24'h0, key_mem[kk]};
            if (kk % 4 == 0) begin
                o = 2 * (15 - kk) + 1;
                e_lwe[o] = 1; e_la[o] = 2'(kk / 4); e_ld[o] = lv[kk/4];
            end
        end
        for (int n = 0; n < 26; n++) begin
            sv[n] = PW_C + QW_C * 32'(n);
            e_swe[32+n] = 1; e_sa[32+n] = 5'(n); e_sd[32+n] = sv[n];
        end
        a = '0; b = '0; ii = 0; jj = 0;
        for (int mm = 0; mm < 78; mm++) begin
            o = 58 + 3 * mm;
            a = rotl32(sv[ii] + a + b, 3);
            sv[ii] = a;
            e_swe[o+1] = 1; e_sa[o+1] = 5'(ii); e_sd[o+1] = a;
            b = rotl32(lv[jj] + a + b, int'((a + b) % 32));
            lv[jj] = b;
            e_lwe[o+2] = 1; e_la[o+2] = 2'(jj); e_ld[o+2] = b;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 4;
        end
        for (int n = 0; n < 26; n++) fin_s[n] = sv[n];
        for (int q = 0; q < 4; q++) fin_l[q] = lv[q];
    endtask

    always @(posedge clk) begin
        bus.key_rdata <= key_mem[bus.key_addr];
        bus.l_rdata   <= l_mem[bus.l_addr];
        bus.s_rdata   <= s_mem[bus.s_addr];
        if (bus.l_we) l_mem[bus.l_addr] <= bus.l_wdata;
        if (bus.s_we) s_mem[bus.s_addr] <= bus.s_wdata;
    end

    // off: -1 idle, 0..291 busy cycle index, 292 the done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) off <= -1;
        else if (off < 0) begin
            if (bus.start) begin
                build_model();
                off <= 0;
            end
        end else if (off == NBUSY) off <= -1;
        else off <= off + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            eb = (off >= 0 && off < NBUSY);
            check("busy", 32'(bus.busy), 32'(eb));
            check("done", 32'(bus.done), 32'(off == NBUSY));
            if (eb) begin
                check("s_we", 32'(bus.s_we), 32'(e_swe[off]));
                if (e_swe[off]) begin
                    check("s_addr", 32'(bus.s_addr), 32'(e_sa[off]));
                    check("s_wdata", bus.s_wdata, e_sd[off]);
                end
                check("l_we", 32'(bus.l_we), 32'(e_lwe[off]));
                if (e_lwe[off]) begin
                    check("l_addr", 32'(bus.l_addr), 32'(e_la[off]));
                    check("l_wdata", bus.l_wdata, e_ld[off]);
                end
                if (off < 32 && off % 2 == 0)
                    check("key_addr", 32'(bus.key_addr), 32'(15 - off / 2));
                if (off < 32 && bus.l_we && ld_n < 4) begin
                    ld_cap[ld_n] = bus.l_wdata;
                    ld_adr[ld_n] = bus.l_addr;
                    ld_n++;
                end
                if (off == 32) cap_s0 = bus.s_wdata;
                if (off == 33) cap_s1 = bus.s_wdata;
                if (off == 57) cap_s25 = bus.s_wdata;
                if (off == 59) begin
                    cap_mix_a = bus.s_addr;
                    cap_mix_d = bus.s_wdata;
                end
            end else begin
                check("idle_s_we", 32'(bus.s_we), 32'd0);
                check("idle_l_we", 32'(bus.l_we), 32'd0);
                check("idle_key_addr", 32'(bus.key_addr), 32'd0);
                check("idle_l_addr", 32'(bus.l_addr), 32'd0);
                check("idle_s_addr", 32'(bus.s_addr), 32'd0);
            end
        end
    end

    task automatic check_mem();
        for (int n = 0; n < 26; n++) check("final_S", s_mem[n], fin_s[n]);
        for (int q = 0; q < 4; q++) check("final_L", l_mem[q], fin_l[q]);
    endtask

    task automatic wait_done(input int poke, input bit hold, output int bcnt);
        bit seen;
        seen = 0;
        bcnt = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            else begin
                if (bus.busy) bcnt++;
                if (!hold) bus.start = (poke > 0 && bcnt == poke);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_one(input int poke);
        int bc;
        @(negedge clk);
        bus.start = 1'b1;
        ld_n = 0;
        wait_done(poke, 1'b0, bc);
        check("busy_len", 32'(bc), 32'(NBUSY));
        check_mem();
        @(negedge clk);
        check("done_len", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] kv;
        int bc;
        bit found;
        lit_l[0] = 32'h03020100; lit_l[1] = 32'h07060504;
        lit_l[2] = 32'h0B0A0908; lit_l[3] = 32'h0F0E0D0C;
        for (int n = 0; n < 16; n++) key_mem[n] = 8'(n);
        for (int q = 0; q < 4; q++) l_mem[q] = '0;
        for (int n = 0; n < 32; n++) s_mem[n] = '0;
        ld_n = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_we", 32'({bus.l_we, bus.s_we}), 32'd0);
        check("rst_addr", 32'({bus.key_addr, bus.l_addr, bus.s_addr}), 32'd0);
        #1 rst = 1'b0;

        // key bytes 0..15, with a spurious start at busy cycle 100
        run_one(100);
        check("load_writes", 32'(ld_n), 32'd4);
        for (int q = 0; q < 4; q++) check("load_L", ld_cap[q], lit_l[ld_adr[q]]);
        check("model_L3", e_ld[7], 32'h0F0E0D0C);
        check("model_L0", e_ld[31], 32'h03020100);
        check("model_L0_addr", 32'(e_la[31]), 32'd0);
        check("init_S0", cap_s0, 32'hB7E15163);
        check("init_S1", cap_s1, 32'h5618CB1C);
        check("init_S25", cap_s25, PW_C + 32'd25 * QW_C);
        check("model_S1", e_sd[33], 32'h5618CB1C);
        check("mix_a_addr", 32'(cap_mix_a), 32'd0);
        check("mix_a_data", cap_mix_d, 32'hBF0A8B1D);
        check("model_mix_a", e_sd[59], 32'hBF0A8B1D);

        for (int n = 0; n < 16; n++) key_mem[n] = 8'h00;
        run_one(0);

        kv = 128'hFFFEEEE58684FFF05FFE493853000434;
        for (int n = 0; n < 16; n++) key_mem[n] = kv[127 - 8*n -: 8];
        run_one($urandom_range(1, 291));

        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 16; n++) key_mem[n] = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_one($urandom_range(1, 291));
        end

        // asynchronous reset in the middle of mixing (m = 40)
        for (int n = 0; n < 16; n++) key_mem[n] = 8'($urandom_range(0, 255));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            if (off == 58 + 3 * 40) found = 1;
            else @(negedge clk);
        end
        check("reach_m40", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_we", 32'({bus.l_we, bus.s_we}), 32'd0);
        check("mid_rst_addr", 32'({bus.key_addr, bus.l_addr, bus.s_addr}), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        run_one(0);

        // start held high: back-to-back expansions with one IDLE cycle between
        for (int n = 0; n < 16; n++) key_mem[n] = 8'($urandom_range(0, 255));
        @(negedge clk);
        bus.start = 1'b1;
        wait_done(0, 1'b1, bc);
        check("held_len1", 32'(bc), 32'(NBUSY));
        check_mem();
        @(negedge clk);
        check("held_fin_gap", 32'({bus.busy, bus.done}), 32'd0);
        wait_done(0, 1'b1, bc);
        bus.start = 1'b0;
        check("held_len2", 32'(bc), 32'(NBUSY));
        check_mem();
        @(negedge clk);
        check("held_done_len", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
